// File: rtl/pit_channel.sv
// One 8253-compatible PIT counter channel: bus decode, byte sequencing, latch,
// reload and OUT generation for modes 0, 2 and 3, stepped by the PIT tick enable.
module pit_channel #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iClkEnPit,
    input  logic       iGate,
    input  logic       iSel,
    input  logic       iWr,
    input  logic       iRd,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    output logic       oOut
);

    localparam int unsigned CW = 17;
    localparam int unsigned RW = 16;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

    logic [CW-1:0] r_count;
    logic [RW-1:0] r_reload;
    mode_e         r_mode;
    logic [1:0]    r_rw;
    logic          r_wr_tog;
    logic          r_rd_tog;
    logic [7:0]    r_lsb;
    logic          r_latched;
    logic [RW-1:0] r_latch;
    logic          r_armed;
    logic          r_load_pend;
    logic          r_out;
    logic [7:0]    r_data;
    logic          r_gate_d;

    logic [CW-1:0] w_count_nxt;
    logic [RW-1:0] w_reload_nxt;
    mode_e         w_mode_nxt;
    logic [1:0]    w_rw_nxt;
    logic          w_wr_tog_nxt;
    logic          w_rd_tog_nxt;
    logic [7:0]    w_lsb_nxt;
    logic          w_latched_nxt;
    logic [RW-1:0] w_latch_nxt;
    logic          w_armed_nxt;
    logic          w_load_pend_nxt;
    logic          w_out_nxt;
    logic [7:0]    w_data_nxt;

    logic [CW-1:0] w_reload_n;
    logic [CW-1:0] w_reload_eff;
    logic [CW-1:0] w_half_hi;
    logic [CW-1:0] w_half_lo;
    logic [CW-1:0] w_dec;
    logic [RW-1:0] w_src;
    logic          w_ctrl;
    logic          w_dwr;
    logic          w_drd;
    logic          w_gate_rise;
    logic          w_wr_done;
    mode_e         w_mode_dec;

    // Reload 0 stands for 65536; modes 2/3 cannot run with a period of 1.
    assign w_reload_n   = (r_reload == '0) ? CW'(17'h10000) : {1'b0, r_reload};
    assign w_reload_eff = ((r_mode != MODE_0) && (w_reload_n == CW'(1))) ? CW'(2) : w_reload_n;
    assign w_half_hi    = (w_reload_eff + CW'(1)) >> 1;
    assign w_half_lo    = w_reload_eff >> 1;
    assign w_dec        = (r_count == '0) ? CW'(17'h0FFFF) : r_count - CW'(1);
    assign w_src        = r_latched ? r_latch : r_count[RW-1:0];
    assign w_ctrl       = iWr && iSel && (iData[7:6] == 2'(CHANNEL));
    assign w_dwr        = iWr && !iSel;
    assign w_drd        = iRd && !iWr && !iSel;
    assign w_gate_rise  = iGate && !r_gate_d;

    always_comb begin
        case (iData[2:1])
            2'b10:   w_mode_dec = MODE_2;
            2'b11:   w_mode_dec = MODE_3;
            default: w_mode_dec = MODE_0;
        endcase
    end

    // Counting first, then gate effects, then bus accesses override.
    always_comb begin
        w_count_nxt     = r_count;
        w_reload_nxt    = r_reload;
        w_mode_nxt      = r_mode;
        w_rw_nxt        = r_rw;
        w_wr_tog_nxt    = r_wr_tog;
        w_rd_tog_nxt    = r_rd_tog;
        w_lsb_nxt       = r_lsb;
        w_latched_nxt   = r_latched;
        w_latch_nxt     = r_latch;
        w_armed_nxt     = r_armed;
        w_load_pend_nxt = r_load_pend;
        w_out_nxt       = r_out;
        w_data_nxt      = r_data;
        w_wr_done       = 1'b0;

        if (iClkEnPit && r_armed) begin
            if (r_load_pend) begin
                w_load_pend_nxt = 1'b0;
                if (r_mode == MODE_3) begin
                    w_count_nxt = w_half_hi;
                    w_out_nxt   = 1'b1;
                end else begin
                    w_count_nxt = w_reload_eff;
                    if (r_mode == MODE_2) w_out_nxt = 1'b1;
                end
            end else if (iGate) begin
                case (r_mode)
                    MODE_0: begin
                        w_count_nxt = w_dec;
                        if (r_count == CW'(1)) w_out_nxt = 1'b1;
                    end
                    MODE_2: begin
                        if (r_count == CW'(1)) begin
                            w_count_nxt = w_reload_eff;
                            w_out_nxt   = 1'b1;
                        end else begin
                            w_count_nxt = w_dec;
                            if (r_count == CW'(2)) w_out_nxt = 1'b0;
                        end
                    end
                    MODE_3: begin
                        if (r_count == CW'(1)) begin
                            w_out_nxt   = !r_out;
                            w_count_nxt = r_out ? w_half_lo : w_half_hi;
                        end else begin
                            w_count_nxt = w_dec;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (r_mode != MODE_0) begin
            if (!iGate) w_out_nxt = 1'b1;
            if (w_gate_rise && r_armed) w_load_pend_nxt = 1'b1;
        end

        if (w_ctrl) begin
            if (iData[5:4] == 2'b00) begin
                if (!r_latched) begin
                    w_latched_nxt = 1'b1;
                    w_latch_nxt   = r_count[RW-1:0];
                end
            end else begin
                w_rw_nxt        = iData[5:4];
                w_mode_nxt      = w_mode_dec;
                w_wr_tog_nxt    = 1'b0;
                w_rd_tog_nxt    = 1'b0;
                w_latched_nxt   = 1'b0;
                w_armed_nxt     = 1'b0;
                w_load_pend_nxt = 1'b0;
                w_out_nxt       = (w_mode_dec != MODE_0);
            end
        end else if (w_dwr) begin
            case (r_rw)
                2'b01: begin
                    w_reload_nxt = {8'h00, iData};
                    w_wr_done    = 1'b1;
                end
                2'b10: begin
                    w_reload_nxt = {iData, 8'h00};
                    w_wr_done    = 1'b1;
                end
                default: begin
                    if (!r_wr_tog) begin
                        w_lsb_nxt    = iData;
                        w_wr_tog_nxt = 1'b1;
                    end else begin
                        w_reload_nxt = {iData, r_lsb};
                        w_wr_tog_nxt = 1'b0;
                        w_wr_done    = 1'b1;
                    end
                end
            endcase
            if (w_wr_done) begin
                if (r_mode == MODE_0) begin
                    w_out_nxt       = 1'b0;
                    w_load_pend_nxt = 1'b1;
                    w_armed_nxt     = 1'b1;
                end else if (!r_armed) begin
                    w_armed_nxt     = 1'b1;
                    w_load_pend_nxt = 1'b1;
                end
            end
        end

        if (w_drd) begin
            case (r_rw)
                2'b01: begin
                    w_data_nxt    = w_src[7:0];
                    w_latched_nxt = 1'b0;
                end
                2'b10: begin
                    w_data_nxt    = w_src[15:8];
                    w_latched_nxt = 1'b0;
                end
                default: begin
                    if (!r_rd_tog) begin
                        w_data_nxt   = w_src[7:0];
                        w_rd_tog_nxt = 1'b1;
                    end else begin
                        w_data_nxt    = w_src[15:8];
                        w_rd_tog_nxt  = 1'b0;
                        w_latched_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_count     <= '0;
            r_reload    <= '0;
            r_mode      <= MODE_0;
            r_rw        <= 2'b11;
            r_wr_tog    <= 1'b0;
            r_rd_tog    <= 1'b0;
            r_lsb       <= '0;
            r_latched   <= 1'b0;
            r_latch     <= '0;
            r_armed     <= 1'b0;
            r_load_pend <= 1'b0;
            r_out       <= 1'b1;
            r_data      <= '0;
            r_gate_d    <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_reload    <= w_reload_nxt;
            r_mode      <= w_mode_nxt;
            r_rw        <= w_rw_nxt;
            r_wr_tog    <= w_wr_tog_nxt;
            r_rd_tog    <= w_rd_tog_nxt;
            r_lsb       <= w_lsb_nxt;
            r_latched   <= w_latched_nxt;
            r_latch     <= w_latch_nxt;
            r_armed     <= w_armed_nxt;
            r_load_pend <= w_load_pend_nxt;
            r_out       <= w_out_nxt;
            r_data      <= w_data_nxt;
            r_gate_d    <= iGate;
        end
    end

    assign oData = r_data;
    assign oOut  = r_out;

endmodule
